glitch_free_clk_switch: RTL and testbench



---
 rtl/glitch_free_pkg.sv | 13 +
 rtl/glitch_free_sync.sv | 23 ++
 rtl/glitch_free_clk_switch.sv | 98 +++++++++
 tb/tb_glitch_free_clk_switch.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/glitch_free_pkg.sv
// rtl/glitch_free_pkg.sv - shared state encoding and source ids for the glitch-free clock switch
package glitch_free_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic SRC_CLK0 = 1'b0;
  localparam logic SRC_CLK1 = 1'b1;

endpackage

// File: rtl/glitch_free_sync.sv
// rtl/glitch_free_sync.sv - flop-chain synchronizer into the sampling clock domain
module glitch_free_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/glitch_free_clk_switch.sv
// rtl/glitch_free_clk_switch.sv - glitch-free two-source clock selector sampled by a fast clock
module glitch_free_clk_switch
  import glitch_free_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk0,
  input  logic clk1,
  input  logic select,
  output logic clkout,
  output logic cur_sel,
  output logic busy
);

  logic   s0;
  logic   s1;
  logic   sel_s;
  logic   src;
  logic   src_q;
  state_t state;

  glitch_free_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk0 (
    .clk (clk),
    .rst (rst),
    .d   (clk0),
    .q   (s0)
  );

  glitch_free_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk1 (
    .clk (clk),
    .rst (rst),
    .d   (clk1),
    .q   (s1)
  );

  glitch_free_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
    .clk (clk),
    .rst (rst),
    .d   (select),
    .q   (sel_s)
  );

  assign src = cur_sel ? s1 : s0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARM;
      cur_sel <= SRC_CLK0;
      clkout  <= 1'b0;
      busy    <= 1'b1;
      src_q   <= 1'b0;
    end else begin
      src_q <= src;
      case (state)
        ARM: begin
          clkout <= 1'b0;
          // A retarget clears the edge history so the old source's level
          // cannot masquerade as a falling edge of the new one.
          if (sel_s != cur_sel) begin
            cur_sel <= sel_s;
            src_q   <= 1'b0;
          end else if (src_q && !src) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          clkout <= src;
          if (sel_s != cur_sel) begin
            state <= DRAIN;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          if (sel_s == cur_sel) begin
            clkout <= src;
            state  <= RUN;
            busy   <= 1'b0;
          end else if (src) begin
            clkout <= 1'b1;
          end else begin
            clkout  <= 1'b0;
            cur_sel <= sel_s;
            state   <= ARM;
          end
        end
        default: begin
          clkout <= 1'b0;
          state  <= ARM;
          busy   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_free_clk_switch.sv
// tb/tb_glitch_free_clk_switch.sv - self-checking bench for the glitch-free clock switch
`timescale 1ns/1ps
module tb_glitch_free_clk_switch;

  logic clk = 1'b0;
  logic rst;
  logic clk0 = 1'b0;
  logic clk1 = 1'b0;
  logic select;
  logic clkout;
  logic cur_sel;
  logic busy;

  int total = 0;
  int bad = 0;

  glitch_free_clk_switch #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .clk0    (clk0),
    .clk1    (clk1),
    .select  (select),
    .clkout  (clkout),
    .cur_sel (cur_sel),
    .busy    (busy)
  );

  always #1 clk = ~clk;

  // Sources toggle on half-ns offsets so they never coincide with a sampling edge.
  initial begin
    real ph0;
    ph0 = real'($urandom_range(0, 29)) + 0.5;
    #(ph0);
    forever #15 clk0 = ~clk0;
  end

  initial begin
    real ph1;
    ph1 = real'($urandom_range(0, 19)) + 0.5;
    #(ph1);
    forever #10 clk1 = ~clk1;
  end

  int   cyc = 0;
  logic h0 [4096];
  logic h1 [4096];

  always @(posedge clk) begin
    cyc = cyc + 1;
    h0[cyc % 4096] = clk0;
    h1[cyc % 4096] = clk1;
  end

  real  last_evt = 0.0;
  logic last_out = 1'bx;
  int   run_len = 0;
  bit   run_valid = 1'b0;
  bit   track_force = 1'b0;
  logic track_sel = 1'b0;
  bit   busy_seen = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d required=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One sampling cycle: reset values, phase-length rules, and exact tracking
  // of the chosen source (sampled two edges earlier) once the switch settles.
  task automatic step();
    logic rst_seen;
    logic ref_v;
    logic exp_sel;
    bit   settled;
    @(negedge clk);
    rst_seen = rst;
    if (rst_seen) begin
      chk("rst_clkout", clkout, 1'b0);
      chk("rst_busy", busy, 1'b1);
      chk("rst_cur_sel", cur_sel, 1'b0);
    end
    if (clkout !== last_out) begin
      if (run_valid && !rst_seen) begin
        if (last_out === 1'b1) chk_range("high_phase", run_len, 4, 8);
        else                   chk_range("low_phase", run_len, 4, 1000000);
      end
      run_valid = !$isunknown(last_out) && !$isunknown(clkout);
      last_out  = clkout;
      run_len   = 1;
    end else begin
      run_len++;
    end
    settled = !rst_seen && ($realtime - last_evt > 80.0) && (cyc > 4);
    if (track_force || settled) begin
      exp_sel = track_force ? track_sel : select;
      ref_v   = exp_sel ? h1[(cyc - 2) % 4096] : h0[(cyc - 2) % 4096];
      chk("track_clkout", clkout, ref_v);
      chk("track_cur_sel", cur_sel, exp_sel);
      if (!track_force) chk("track_busy", busy, 1'b0);
    end
    if (busy === 1'b1) busy_seen = 1'b1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_sel(input logic v);
    #0.25;
    select   = v;
    last_evt = $realtime;
  endtask

  task automatic wait_rise(input logic which);
    logic prev;
    logic now_v;
    prev = which ? clk1 : clk0;
    for (int i = 0; i < 40; i++) begin
      step();
      now_v = which ? clk1 : clk0;
      if (now_v && !prev) break;
      prev = now_v;
    end
  endtask

  initial begin
    bit found;
    rst    = 1'b1;
    select = 1'b0;

    // Reset held for 5 cycles, then lock onto clk0.
    steps(5);
    rst      = 1'b0;
    last_evt = $realtime;
    steps(120);
    chk("t1_busy", busy, 1'b0);

    // Select pulse shorter than a clk0 high phase: output must not be gated.
    wait_rise(1'b0);
    busy_seen   = 1'b0;
    track_sel   = 1'b0;
    track_force = 1'b1;
    step();
    set_sel(1'b1);
    step();
    step();
    set_sel(1'b0);
    steps(30);
    track_force = 1'b0;
    chk("t3_busy_pulse", busy_seen, 1'b1);
    steps(60);

    // Switch 0->1 while clk0 is high.
    wait_rise(1'b0);
    steps(int'($urandom_range(0, 2)));
    set_sel(1'b1);
    steps(100);
    chk("t2_cur_sel", cur_sel, 1'b1);

    // Switch 1->0 while clk1 is high.
    wait_rise(1'b1);
    set_sel(1'b0);
    steps(100);
    chk("t4_cur_sel", cur_sel, 1'b0);
    chk("t4_busy", busy, 1'b0);

    // Reset while clkout is high on clk1.
    set_sel(1'b1);
    steps(100);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (clkout === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_clkout_high_seen", found, 1'b1);
    rst      = 1'b1;
    select   = 1'b0;
    last_evt = $realtime;
    step();
    rst      = 1'b0;
    last_evt = $realtime;
    steps(100);
    chk("t5_cur_sel", cur_sel, 1'b0);

    // Random select activity, including changes mid-switch.
    for (int k = 0; k < 8; k++) begin
      steps(int'($urandom_range(1, 60)));
      set_sel(1'($urandom_range(0, 1)));
    end
    steps(120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
